wormhole_grant_ctrl: RTL and testbench

- Output-port allocation controller for the 5-port (L, N, E, W, S) NoC router.
- Grants one output port to one input requester for a whole wormhole packet, from header flit to tail flit.
- Picks the winner round-robin.
- A watchdog reclaims the port from a stalled packet.
- One instance per output port; it drives the crossbar select and the per-input ready lines.

---
 rtl/wormhole_grant_if.sv | 21 ++
 rtl/wormhole_grant_ctrl.sv | 93 +++++++++
 tb/tb_wormhole_grant_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wormhole_grant_if.sv
// wormhole_grant_if: handshake, grant and status bundle for one router output port
interface wormhole_grant_if;
  logic [4:0]  in_valid;
  logic [14:0] in_flit_id;
  logic        out_ready;
  logic [4:0]  in_ready;
  logic        out_valid;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic        timeout_pulse;
  logic        timeout_err;
  logic [15:0] pkt_count;
  modport master (
    output in_valid, in_flit_id, out_ready,
    input  in_ready, out_valid, grant, sel, timeout_pulse, timeout_err, pkt_count
  );
  modport slave (
    input  in_valid, in_flit_id, out_ready,
    output in_ready, out_valid, grant, sel, timeout_pulse, timeout_err, pkt_count
  );
endinterface

// File: rtl/wormhole_grant_ctrl.sv
// wormhole_grant_ctrl: per-output-port wormhole allocator with round-robin arbitration and stall watchdog
module wormhole_grant_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CW = 12
) (
  input logic clk,
  input logic rst,
  wormhole_grant_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;
  state_t state, state_nx;
  logic [2:0] g, g_nx, lw, lw_nx, win, idx, fid_g;
  logic [CW-1:0] wd, wd_nx;
  logic [4:0] cand;
  logic found, vg, xfer, tail, err;
  logic [15:0] cnt;
  // header candidates and round-robin winner starting after the last owner
  always_comb begin
    cand = '0;
    found = 1'b0;
    win = 3'd0;
    idx = 3'd0;
    for (int i = 0; i < 5; i++) cand[i] = bus.in_valid[i] & bus.in_flit_id[3*i+2] & bus.in_flit_id[3*i+1];
    for (int i = 1; i <= 5; i++) begin
      idx = 3'((int'(lw) + i) % 5);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // view of the granted input and transfer/tail detection
  always_comb begin
    vg = 1'b0;
    fid_g = 3'd0;
    for (int i = 0; i < 5; i++) if (g == 3'(i)) begin
      vg = bus.in_valid[i];
      fid_g = bus.in_flit_id[3*i +: 3];
    end
    xfer = (state == XFER) && vg && bus.out_ready;
    tail = (fid_g == 3'b001) || (fid_g == 3'b111);
  end
  // next-state, owner, priority pointer and watchdog
  always_comb begin
    state_nx = state;
    g_nx = g;
    lw_nx = lw;
    wd_nx = wd;
    if (state == IDLE) begin
      if (found) begin
        state_nx = XFER;
        g_nx = win;
        wd_nx = '0;
      end
    end else if (state == XFER) begin
      if (xfer) begin
        wd_nx = '0;
        if (tail) begin
          state_nx = IDLE;
          lw_nx = g;
        end
      end else if (wd == CW'(TIMEOUT - 1)) begin
        state_nx = ABORT;
        lw_nx = g;
      end else if (wd != '1) wd_nx = wd + CW'(1);
    end else state_nx = IDLE;
  end
  // state registers; sticky error and packet counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      g <= 3'd0;
      lw <= 3'd4;
      wd <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      g <= g_nx;
      lw <= lw_nx;
      wd <= wd_nx;
      if (state_nx == ABORT) err <= 1'b1;
      if (xfer && tail) cnt <= cnt + 16'd1;
    end
  end
  assign bus.in_ready = (state == XFER && bus.out_ready) ? 5'(1) << g : 5'd0;
  assign bus.out_valid = (state == XFER) && vg;
  assign bus.grant = (state == XFER) ? 5'(1) << g : 5'd0;
  assign bus.sel = (state == XFER) ? g : 3'd7;
  assign bus.timeout_pulse = (state == ABORT);
  assign bus.timeout_err = err;
  assign bus.pkt_count = cnt;
endmodule

// File: tb/tb_wormhole_grant_ctrl.sv
// tb_wormhole_grant_ctrl: directed scoreboard bench for the wormhole output-port allocator
module tb_wormhole_grant_ctrl;
  localparam logic [2:0] HEAD = 3'b110, BODY = 3'b010, TAIL = 3'b001, HT = 3'b111;
  typedef struct {logic [2:0] src; logic [2:0] fid;} exp_t;
  logic clk, rst;
  int pass, total;
  exp_t q[$];
  wormhole_grant_if bus();
  wormhole_grant_ctrl #(.TIMEOUT(64), .CW(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(int i, logic v, logic [2:0] f);
    bus.in_valid[i] = v;
    bus.in_flit_id[3*i +: 3] = f;
  endtask
  task automatic send(int i, logic [2:0] f);
    set_in(i, 1'b1, f);
    q.push_back('{3'(i), f});
  endtask
  task automatic pkt2(int i);
    send(i, HEAD);
    cyc();
    chk("rr_grant", 32'(bus.grant), 32'(1) << i);
    cyc();
    send(i, TAIL);
    cyc();
    chk("rr_release", 32'(bus.grant), 0);
    set_in(i, 1'b1, HEAD);
  endtask
  // scoreboard: every accepted flit must match the next expected source/type
  always @(negedge clk) begin
    chk("invariant", 32'($onehot0(bus.grant) && ((bus.sel == 3'd7) == (bus.grant == 5'd0))
        && (bus.in_ready == 5'd0 || bus.grant != 5'd0)), 1);
    if (bus.out_valid && bus.out_ready && bus.in_ready != 5'd0) begin
      if (q.size() == 0) chk("spurious_xfer", 32'(bus.in_ready), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("xfer_src", 32'(bus.sel), 32'(e.src));
        chk("xfer_fid", 32'(bus.in_flit_id[3*e.src +: 3]), 32'(e.fid));
        chk("xfer_rdy", 32'(bus.in_ready), 32'(1) << e.src);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0;
    bus.in_valid = '0;
    bus.in_flit_id = '0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_sel", 32'(bus.sel), 7);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_ovalid", 32'(bus.out_valid), 0);
    chk("rst_pulse", 32'(bus.timeout_pulse), 0);
    chk("rst_err", 32'(bus.timeout_err), 0);
    chk("rst_cnt", 32'(bus.pkt_count), 0);
    rst = 1'b1;
    cyc();
    bus.out_ready = 1'b1;
    send(0, HEAD);
    #1;
    chk("arb_noready", 32'(bus.in_ready), 0);
    cyc();
    chk("l_grant", 32'(bus.grant), 1);
    chk("l_sel", 32'(bus.sel), 0);
    cyc();
    send(0, BODY);
    cyc();
    send(0, TAIL);
    cyc();
    chk("l_release", 32'(bus.grant), 0);
    chk("l_sel_free", 32'(bus.sel), 7);
    chk("l_cnt", 32'(bus.pkt_count), 1);
    set_in(0, 1'b0, 3'd0);
    set_in(2, 1'b1, HEAD);
    set_in(4, 1'b1, HEAD);
    pkt2(1);
    pkt2(2);
    pkt2(4);
    pkt2(1);
    for (int i = 1; i < 5; i++) set_in(i, 1'b0, 3'd0);
    chk("rr_cnt", 32'(bus.pkt_count), 5);
    send(3, HEAD);
    cyc();
    chk("w_grant", 32'(bus.grant), 8);
    cyc();
    set_in(3, 1'b0, BODY);
    repeat (63) cyc();
    chk("wd_pre_pulse", 32'(bus.timeout_pulse), 0);
    chk("wd_pre_grant", 32'(bus.grant), 8);
    cyc();
    chk("wd_pulse", 32'(bus.timeout_pulse), 1);
    chk("wd_err", 32'(bus.timeout_err), 1);
    chk("wd_grant", 32'(bus.grant), 0);
    chk("wd_sel", 32'(bus.sel), 7);
    chk("wd_cnt", 32'(bus.pkt_count), 5);
    cyc();
    chk("wd_pulse_end", 32'(bus.timeout_pulse), 0);
    chk("wd_err_sticky", 32'(bus.timeout_err), 1);
    send(0, HEAD);
    cyc();
    chk("stall_grant", 32'(bus.grant), 1);
    cyc();
    bus.out_ready = 1'b0;
    send(0, BODY);
    repeat (10) begin
      cyc();
      chk("stall_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_resume", 32'(bus.in_ready), 1);
    cyc();
    send(0, TAIL);
    cyc();
    chk("stall_release", 32'(bus.grant), 0);
    chk("stall_nopulse", 32'(bus.timeout_pulse), 0);
    chk("stall_cnt", 32'(bus.pkt_count), 6);
    set_in(0, 1'b0, 3'd0);
    set_in(1, 1'b1, BODY);
    send(2, HT);
    #1;
    chk("ht_arb_ready", 32'(bus.in_ready), 0);
    cyc();
    chk("ht_grant", 32'(bus.grant), 4);
    chk("ht_ready", 32'(bus.in_ready), 4);
    cyc();
    chk("ht_release", 32'(bus.grant), 0);
    chk("ht_cnt", 32'(bus.pkt_count), 7);
    set_in(2, 1'b0, 3'd0);
    #1;
    chk("body_noready", 32'(bus.in_ready), 0);
    cyc();
    chk("body_nogrant", 32'(bus.grant), 0);
    set_in(1, 1'b0, 3'd0);
    send(4, HEAD);
    cyc();
    chk("s_grant", 32'(bus.grant), 16);
    cyc();
    bus.out_ready = 1'b0;
    set_in(4, 1'b1, BODY);
    rst = 1'b0;
    cyc();
    chk("mrst_grant", 32'(bus.grant), 0);
    chk("mrst_sel", 32'(bus.sel), 7);
    chk("mrst_cnt", 32'(bus.pkt_count), 0);
    chk("mrst_err", 32'(bus.timeout_err), 0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_in(4, 1'b1, HEAD);
    send(0, HEAD);
    cyc();
    chk("mrst_lfirst", 32'(bus.grant), 1);
    cyc();
    set_in(4, 1'b0, 3'd0);
    send(0, TAIL);
    cyc();
    chk("mrst_release", 32'(bus.grant), 0);
    chk("mrst_cnt1", 32'(bus.pkt_count), 1);
    set_in(0, 1'b0, 3'd0);
    cyc();
    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
